stepper_step_generator: RTL

- Motion-profile front end for the unipolar stepper drive stage. It converts a move command into a timed train of step pulses plus a stable direction level.
- Command fields: step count, start/min period and acceleration decrement.
- step_out drives the winding sequencer's clock input; direction drives its direction input.
- Produces a trapezoidal (accelerate/cruise/decelerate) velocity profile with a busy/done handshake for the Nios-side register interface.

---
 rtl/stepper_pkg.sv | 19 +
 rtl/stepper_step_generator_if.sv | 39 +++
 rtl/step_pulse_timer.sv | 64 ++++++
 rtl/stepper_step_generator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper step generator.
//   step_state_t : motion profile phase (IDLE, ACCEL, CRUISE, DECEL)
//   DEF_CNT_W    : default width of step count and ramp counters
//   DEF_PER_W    : default width of period values in clk cycles
//   CLK_HZ       : system clock frequency the period values are scaled to
package stepper_pkg;

    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned DEF_PER_W = 24;
    localparam int unsigned CLK_HZ    = 12_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } step_state_t;

endpackage

// File: rtl/stepper_step_generator_if.sv
// Command/status bundle between the Nios-side register block and the
// stepper step generator.
//   master : register block (drives command fields, reads status/pulses)
//   slave  : step generator
// Signals:
//   start, dir_in, steps, start_period, min_period, accel_dec : move command
//   abort                                 : level stop request
//   step_out, direction                   : to the winding sequencer
//   busy, done, remaining                 : move status
interface stepper_step_generator_if
    import stepper_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PER_W = DEF_PER_W
);
    logic             start;
    logic             dir_in;
    logic [CNT_W-1:0] steps;
    logic [PER_W-1:0] start_period;
    logic [PER_W-1:0] min_period;
    logic [PER_W-1:0] accel_dec;
    logic             abort;
    logic             step_out;
    logic             direction;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, dir_in, steps, start_period, min_period, accel_dec, abort,
        input  step_out, direction, busy, done, remaining
    );

    modport slave (
        input  start, dir_in, steps, start_period, min_period, accel_dec, abort,
        output step_out, direction, busy, done, remaining
    );

endinterface

// File: rtl/step_pulse_timer.sv
// Period down-counter and step pulse stretcher.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load the counter with load_val (start of a move)
//   load_val    : first period minus one
//   run         : counter enabled (move active and more steps scheduled)
//   reload_val  : next period minus one, taken at a step boundary
//   boundary    : step boundary strobe (counter at zero while running)
//   step_out    : step pulse, high for PULSE_W cycles after each boundary
//   pulse_end   : last high cycle of the current step pulse
module step_pulse_timer #(
    parameter int PER_W   = 24,
    parameter int PULSE_W = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    input  logic             run,
    input  logic [PER_W-1:0] reload_val,
    output logic             boundary,
    output logic             step_out,
    output logic             pulse_end
);

    localparam int PW_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    logic [PER_W-1:0] timer;
    logic [PW_W-1:0]  pulse_cnt;
    logic             pulse_q;

    assign boundary  = run && (timer == '0);
    assign pulse_end = pulse_q && (pulse_cnt == '0);
    assign step_out  = pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (load) begin
            timer <= load_val;
        end else if (boundary) begin
            timer <= reload_val;
        end else if (run) begin
            timer <= timer - 1'b1;
        end
    end

    // pulse_cnt holds the high cycles still owed after the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q   <= 1'b0;
            pulse_cnt <= '0;
        end else if (boundary) begin
            pulse_q   <= 1'b1;
            pulse_cnt <= PW_W'(PULSE_W - 1);
        end else if (pulse_q) begin
            if (pulse_cnt == '0) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_cnt <= pulse_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/stepper_step_generator.sv
// Trapezoidal motion profile step generator for the unipolar stepper drive.
// Converts a move command into a train of PULSE_W-wide step pulses with an
// accelerate / cruise / decelerate period profile.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command/status bundle (slave side)
//                start/dir_in/steps/start_period/min_period/accel_dec in,
//                abort in, step_out/direction/busy/done/remaining out
module stepper_step_generator
    import stepper_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PER_W   = DEF_PER_W,
    parameter int PULSE_W = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stepper_step_generator_if.slave  bus
);

    // Period may never drop below twice the pulse width so pulses never merge
    localparam logic [PER_W-1:0] PULSE_FLOOR = PER_W'(2 * PULSE_W);

    step_state_t      state, state_n;
    logic             stopping, stopping_n;
    logic [PER_W-1:0] period, period_n;
    logic [PER_W-1:0] pmin_q, pmin_n;
    logic [PER_W-1:0] pstart_q, pstart_n;
    logic [PER_W-1:0] dec_q, dec_n;
    logic [CNT_W-1:0] ramp_cnt, ramp_n;
    logic [CNT_W-1:0] remaining_q, remaining_n;
    logic             direction_q, direction_n;
    logic             done_q, done_n;

    logic [PER_W-1:0] pmin_in, pstart_in;
    logic [PER_W-1:0] accel_period, decel_period;
    logic [PER_W-1:0] load_val, reload_val;
    logic [CNT_W-1:0] ramp_inc, remaining_dec;
    logic             load, run, boundary, pulse_end, step_pulse;

    assign pmin_in   = (bus.min_period > PULSE_FLOOR) ? bus.min_period : PULSE_FLOOR;
    assign pstart_in = (bus.start_period > pmin_in) ? bus.start_period : pmin_in;

    // period always lies in [pmin_q, pstart_q], so these differences cannot wrap
    assign accel_period = ((period - pmin_q) > dec_q) ? (period - dec_q) : pmin_q;
    assign decel_period = ((pstart_q - period) > dec_q) ? (period + dec_q) : pstart_q;

    assign ramp_inc      = ramp_cnt + 1'b1;
    assign remaining_dec = remaining_q - 1'b1;

    // Once the last step has been scheduled the counter freezes until the
    // in-flight pulse has finished and the move is retired.
    assign run = (state != IDLE) && !stopping;

    step_pulse_timer #(
        .PER_W   (PER_W),
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .run        (run),
        .reload_val (reload_val),
        .boundary   (boundary),
        .step_out   (step_pulse),
        .pulse_end  (pulse_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stopping    <= 1'b0;
            period      <= '0;
            pmin_q      <= '0;
            pstart_q    <= '0;
            dec_q       <= '0;
            ramp_cnt    <= '0;
            remaining_q <= '0;
            direction_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            stopping    <= stopping_n;
            period      <= period_n;
            pmin_q      <= pmin_n;
            pstart_q    <= pstart_n;
            dec_q       <= dec_n;
            ramp_cnt    <= ramp_n;
            remaining_q <= remaining_n;
            direction_q <= direction_n;
            done_q      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        stopping_n  = stopping;
        period_n    = period;
        pmin_n      = pmin_q;
        pstart_n    = pstart_q;
        dec_n       = dec_q;
        ramp_n      = ramp_cnt;
        remaining_n = remaining_q;
        direction_n = direction_q;
        done_n      = 1'b0;
        load        = 1'b0;
        load_val    = pstart_in - 1'b1;
        reload_val  = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.steps != '0) begin
                        state_n     = ACCEL;
                        stopping_n  = 1'b0;
                        direction_n = bus.dir_in;
                        remaining_n = bus.steps;
                        period_n    = pstart_in;
                        pmin_n      = pmin_in;
                        pstart_n    = pstart_in;
                        dec_n       = bus.accel_dec;
                        ramp_n      = '0;
                        load        = 1'b1;
                    end else begin
                        remaining_n = '0;
                        done_n      = 1'b1;
                    end
                end
            end
            default: begin
                if (stopping) begin
                    if (pulse_end) begin
                        state_n    = IDLE;
                        stopping_n = 1'b0;
                        done_n     = 1'b1;
                    end
                end else if (boundary) begin
                    // The step rising at this boundary is always issued;
                    // abort or the last step only prevents further ones.
                    remaining_n = remaining_dec;
                    if ((remaining_dec == '0) || bus.abort) begin
                        stopping_n = 1'b1;
                    end
                    case (state)
                        ACCEL: begin
                            period_n = accel_period;
                            ramp_n   = ramp_inc;
                            if (remaining_dec <= ramp_inc) begin
                                state_n = DECEL;
                            end else if (accel_period == pmin_q) begin
                                state_n = CRUISE;
                            end
                        end
                        CRUISE: begin
                            if (remaining_dec <= ramp_cnt) begin
                                state_n = DECEL;
                            end
                        end
                        DECEL: begin
                            period_n = decel_period;
                            if (ramp_cnt != '0) begin
                                ramp_n = ramp_cnt - 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase

        reload_val = period_n - 1'b1;
    end

    assign bus.step_out  = step_pulse;
    assign bus.direction = direction_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;

endmodule
